// File: rtl/sdram_cmd_arbiter.sv
// SDRAM bus arbiter: init, auto-refresh and NUM_CH access engines share pins.
// Optional grant watchdog with wdog_err output: define SDRAM_ARB_WDOG_EN.
module sdram_cmd_arbiter #(
    parameter int NUM_CH   = 2,
    parameter int ADDR_W   = 13,
    parameter int DATA_W   = 16,
    parameter int ARB_MODE = 0,
    parameter int TIMEOUT  = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     init_end,
    input  logic [3:0]               init_cmd,
    input  logic [1:0]               init_ba,
    input  logic [ADDR_W-1:0]        init_addr,
    input  logic                     aref_req,
    input  logic                     aref_end,
    input  logic [3:0]               aref_cmd,
    input  logic [1:0]               aref_ba,
    input  logic [ADDR_W-1:0]        aref_addr,
    output logic                     aref_en,
    input  logic [NUM_CH-1:0]        ch_req,
    input  logic [NUM_CH-1:0]        ch_end,
    input  logic [4*NUM_CH-1:0]      ch_cmd,
    input  logic [2*NUM_CH-1:0]      ch_ba,
    input  logic [ADDR_W*NUM_CH-1:0] ch_addr,
    input  logic [NUM_CH-1:0]        ch_dq_oe,
    input  logic [DATA_W*NUM_CH-1:0] ch_dq,
    output logic [NUM_CH-1:0]        ch_en,
    output logic [3:0]               sdram_cmd,
    output logic [1:0]               sdram_ba,
    output logic [ADDR_W-1:0]        sdram_addr,
    output logic                     sdram_dq_oe,
    output logic [DATA_W-1:0]        sdram_dq_out,
`ifdef SDRAM_ARB_WDOG_EN
    output logic                     wdog_err,
`endif
    output logic                     busy
);

    localparam int SEL_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [3:0] CMD_NOP = 4'b0111;

    typedef enum logic [1:0] {
        S_INIT,
        S_ARBIT,
        S_AREF,
        S_ACCESS
    } state_t;

    state_t              r_state;
    logic [SEL_W-1:0]    r_sel;
    logic [SEL_W-1:0]    r_rr;
    logic                r_aref_en;
    logic [NUM_CH-1:0]   r_ch_en;

    logic                w_found;
    logic [SEL_W-1:0]    w_pick;
    logic [SEL_W-1:0]    w_pos;
    logic [SEL_W-1:0]    w_rr_next;

`ifdef SDRAM_ARB_WDOG_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0]    r_cnt;
    logic                r_wdog_err;
    logic                w_expire;

    assign w_expire = (r_cnt == CNT_W'(TIMEOUT - 1));
    assign wdog_err = r_wdog_err;
`endif

    // Pick the winning channel: lowest index, or first at/after rr pointer
    always_comb begin
        w_found = 1'b0;
        w_pick  = '0;
        w_pos   = '0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (ARB_MODE == 0) begin
                w_pos = SEL_W'(k);
            end else begin
                w_pos = SEL_W'((int'(r_rr) + k) % NUM_CH);
            end
            if (!w_found && ch_req[w_pos]) begin
                w_found = 1'b1;
                w_pick  = w_pos;
            end
        end
        w_rr_next = SEL_W'((int'(w_pick) + 1) % NUM_CH);
    end

    // Arbiter FSM: grants, owner index and round-robin pointer
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_INIT;
            r_aref_en <= 1'b0;
            r_ch_en   <= '0;
            r_sel     <= '0;
            r_rr      <= '0;
`ifdef SDRAM_ARB_WDOG_EN
            r_cnt      <= '0;
            r_wdog_err <= 1'b0;
`endif
        end else begin
`ifdef SDRAM_ARB_WDOG_EN
            r_wdog_err <= 1'b0;
`endif
            case (r_state)
                S_INIT: begin
                    if (init_end) begin
                        r_state <= S_ARBIT;
                    end
                end
                S_ARBIT: begin
                    if (aref_req) begin
                        r_state   <= S_AREF;
                        r_aref_en <= 1'b1;
`ifdef SDRAM_ARB_WDOG_EN
                        r_cnt     <= '0;
`endif
                    end else if (w_found) begin
                        r_state <= S_ACCESS;
                        r_ch_en <= NUM_CH'(1) << w_pick;
                        r_sel   <= w_pick;
                        r_rr    <= w_rr_next;
`ifdef SDRAM_ARB_WDOG_EN
                        r_cnt   <= '0;
`endif
                    end
                end
                S_AREF: begin
                    if (aref_end) begin
                        r_state   <= S_ARBIT;
                        r_aref_en <= 1'b0;
`ifdef SDRAM_ARB_WDOG_EN
                    end else if (w_expire) begin
                        r_state    <= S_ARBIT;
                        r_aref_en  <= 1'b0;
                        r_wdog_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                S_ACCESS: begin
                    if (ch_end[r_sel]) begin
                        r_state <= S_ARBIT;
                        r_ch_en <= '0;
`ifdef SDRAM_ARB_WDOG_EN
                    end else if (w_expire) begin
                        r_state    <= S_ARBIT;
                        r_ch_en    <= '0;
                        r_wdog_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
`endif
                    end
                end
                default: begin
                    r_state <= S_INIT;
                end
            endcase
        end
    end

    // Pin mux: current owner drives the bus, ARBIT drives NOP
    always_comb begin
        sdram_cmd    = CMD_NOP;
        sdram_ba     = 2'b00;
        sdram_addr   = '0;
        sdram_dq_oe  = 1'b0;
        sdram_dq_out = '0;
        case (r_state)
            S_INIT: begin
                sdram_cmd  = init_cmd;
                sdram_ba   = init_ba;
                sdram_addr = init_addr;
            end
            S_AREF: begin
                sdram_cmd  = aref_cmd;
                sdram_ba   = aref_ba;
                sdram_addr = aref_addr;
            end
            S_ACCESS: begin
                sdram_cmd    = ch_cmd[4*int'(r_sel) +: 4];
                sdram_ba     = ch_ba[2*int'(r_sel) +: 2];
                sdram_addr   = ch_addr[ADDR_W*int'(r_sel) +: ADDR_W];
                sdram_dq_oe  = ch_dq_oe[r_sel];
                sdram_dq_out = ch_dq[DATA_W*int'(r_sel) +: DATA_W];
            end
            default: begin
                sdram_cmd = CMD_NOP;
            end
        endcase
    end

    assign aref_en = r_aref_en;
    assign ch_en   = r_ch_en;
    assign busy    = (r_state != S_ARBIT);

endmodule

// File: doc/sdram_cmd_arbiter.md
Name: sdram_cmd_arbiter

Overview:
Parametrised SDRAM bus arbiter sitting between the init, auto-refresh and NUM_CH access engines (write, read, …) and the SDRAM pins. It hands out exclusive command/address/data-bus ownership with a request/enable/end handshake. Auto-refresh always outranks access channels, and channel arbitration is fixed-priority or round-robin. It replaces ad-hoc two-way muxing of the command, bank, address and DQ buses.

Parameters:
NUM_CH, 2, number of access channels (2..8)
ADDR_W, 13, SDRAM address bus width
DATA_W, 16, SDRAM DQ width
ARB_MODE, 0, 0 = fixed priority (lowest index wins); 1 = round-robin
TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
clk  in  1  SDRAM controller clock (100 MHz domain)
reset  in  1  asynchronous reset, active-high
init_end  in  1  init sequence complete (level)
init_cmd  in  4  init command {cs_n,ras_n,cas_n,we_n}
init_ba  in  2  init bank address
init_addr  in  ADDR_W  init address
aref_req  in  1  refresh request (level, held until aref_en)
aref_end  in  1  refresh done pulse
aref_cmd  in  4  refresh command
aref_ba  in  2  refresh bank
aref_addr  in  ADDR_W  refresh address
aref_en  out  1  refresh granted
ch_req  in  NUM_CH  per-channel request (level)
ch_end  in  NUM_CH  per-channel done pulse
ch_cmd  in  4*NUM_CH  packed commands, channel i at [4i+3:4i]
ch_ba  in  2*NUM_CH  packed banks
ch_addr  in  ADDR_W*NUM_CH  packed addresses
ch_dq_oe  in  NUM_CH  per-channel DQ drive enable
ch_dq  in  DATA_W*NUM_CH  packed write data
ch_en  out  NUM_CH  one-hot channel grant
sdram_cmd  out  4  muxed command
sdram_ba  out  2  muxed bank
sdram_addr  out  ADDR_W  muxed address
sdram_dq_oe  out  1  tristate enable for DQ pad
sdram_dq_out  out  DATA_W  DQ drive value
busy  out  1  high when not in ARBIT

Behaviour:
- States: INIT, ARBIT, AREF, ACCESS. Reset: state INIT, aref_en=0, ch_en=0, rr pointer=0.
- INIT: outputs mux the init_* inputs; sdram_dq_oe=0. When init_end=1 at a clock edge, go to ARBIT. init_end is ignored after it has been seen; only reset re-enters INIT.
- ARBIT: sdram_cmd=4'b0111 (NOP), sdram_ba=0, sdram_addr=0, dq_oe=0.
  - If aref_req=1: go to AREF and set aref_en on the next edge.
  - Else if any ch_req=1: select one channel, go to ACCESS and set ch_en[sel] on the next edge.
  - Grant latency is 1 cycle from request sampled in ARBIT.
- Selection rules:
  - ARB_MODE 0: lowest set index.
  - ARB_MODE 1: first set index at or after the rr pointer, wrapping. On grant, pointer := sel+1 mod NUM_CH.
- AREF: outputs mux the aref_* inputs. On aref_end=1, clear aref_en and return to ARBIT on the same edge.
- ACCESS: outputs mux channel sel, including ch_dq_oe[sel] and ch_dq[sel]. On ch_end[sel]=1, clear ch_en and return to ARBIT.
- Every ownership change passes through at least one ARBIT (NOP) cycle.
- No pre-emption. aref_req raised during ACCESS waits for that channel's end and then wins the next ARBIT over all channels.
- ch_end/aref_end from non-owners are ignored. ch_req from the owner is ignored while it holds ch_en.
- Simultaneous aref_req and ch_req in ARBIT: refresh wins, and the rr pointer is not advanced.
- Asynchronous reset mid-ACCESS: grants drop immediately, sdram_dq_oe=0, state returns to INIT.
- busy = (state != ARBIT).

Optional Feature:
Macro SDRAM_ARB_WDOG_EN.
- Defined: adds a counter cleared on entry to AREF or ACCESS. If it reaches TIMEOUT with no end pulse, the arbiter forces the grant low and returns to ARBIT. It also pulses an extra output port wdog_err (1 bit, reset 0) high for one cycle; the rr pointer still advances.
- Undefined: no counter and no wdog_err port; a grant is held indefinitely until its end pulse.

Test Plan:
- Reset, then init_end rises at cycle 20 -> sdram_cmd tracks init_cmd until then; NOP at cycle 21; ch_en=0 throughout.
- ARB_MODE 0, ch_req=2'b11 held, each end after 5 cycles -> ch_en=01 granted every time, channel 1 starved; one NOP cycle between grants.
- ARB_MODE 1, NUM_CH=3, ch_req=3'b111 held -> grant order 001,010,100,001; sdram_addr equals the granted channel's ch_addr during each grant.
- aref_req raised mid-ACCESS on ch0 -> ch0 finishes, then one NOP, then aref_en=1 even with ch_req=11; aref_cmd visible on sdram_cmd.
- ch1 owns the bus with ch_dq_oe[1]=1 and ch_dq=16'hA5A5; ch0 pulses ch_end -> ch1 grant unaffected; sdram_dq_out=16'hA5A5 and sdram_dq_oe=1.
- With SDRAM_ARB_WDOG_EN and TIMEOUT=16, a granted channel never ends -> ch_en drops after 16 cycles; wdog_err pulses once; next requester is granted.
